// File: rtl/mod_sub_ctrl_if.sv
// Request/result bundle between a requesting control unit and the
// repeated-subtraction divider.
interface mod_sub_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] value;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             divisible;
   logic             err;

   modport master (
      output start, value, divisor,
      input  busy, done, quot, rem, divisible, err
   );

   modport slave (
      input  start, value, divisor,
      output busy, done, quot, rem, divisible, err
   );
endinterface

// File: rtl/mod_sub_ctrl.sv
// Sequential divider: one compare/subtract per clock, reporting quotient,
// remainder, divisibility and divide-by-zero on a start/busy/done handshake.
module mod_sub_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   mod_sub_ctrl_if.slave      bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;

   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] div_r;
   logic [WIDTH-1:0] quot_r;

   logic [WIDTH-1:0] res_quot_r;
   logic [WIDTH-1:0] res_rem_r;
   logic             res_divisible_r;
   logic             res_err_r;

   logic             load_s;
   logic             sub_s;
   logic             fin_zero_s;
   logic             fin_ok_s;
   logic             busy_s;
   logic             done_s;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and datapath strobes; zero divisor wins over the compare.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      sub_s       = 1'b0;
      fin_zero_s  = 1'b0;
      fin_ok_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               load_s      = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (div_r == {WIDTH{1'b0}}) begin
               fin_zero_s  = 1'b1;
               state_nxt_s = ST_DONE;
            end else if (rem_r >= div_r) begin
               sub_s       = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               fin_ok_s    = 1'b1;
               state_nxt_s = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      busy_s = 1'b0;
      done_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
         ST_RUN: begin
            busy_s = 1'b1;
            done_s = 1'b0;
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
            done_s = 1'b0;
         end
      endcase
   end

   // Working registers: capture on accept, then subtract until rem_r < div_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r  <= {WIDTH{1'b0}};
         div_r  <= {WIDTH{1'b0}};
         quot_r <= {WIDTH{1'b0}};
      end else if (load_s) begin
         rem_r  <= bus.value;
         div_r  <= bus.divisor;
         quot_r <= {WIDTH{1'b0}};
      end else if (sub_s) begin
         rem_r  <= rem_r - div_r;
         quot_r <= quot_r + WIDTH'(1);
      end
   end

   // Result registers update only on entry to DONE and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_quot_r      <= {WIDTH{1'b0}};
         res_rem_r       <= {WIDTH{1'b0}};
         res_divisible_r <= 1'b0;
         res_err_r       <= 1'b0;
      end else if (fin_zero_s) begin
         res_quot_r      <= {WIDTH{1'b0}};
         res_rem_r       <= rem_r;
         res_divisible_r <= 1'b0;
         res_err_r       <= 1'b1;
      end else if (fin_ok_s) begin
         res_quot_r      <= quot_r;
         res_rem_r       <= rem_r;
         res_divisible_r <= (rem_r == {WIDTH{1'b0}});
         res_err_r       <= 1'b0;
      end
   end

   assign bus.busy      = busy_s;
   assign bus.done      = done_s;
   assign bus.quot      = res_quot_r;
   assign bus.rem       = res_rem_r;
   assign bus.divisible = res_divisible_r;
   assign bus.err       = res_err_r;

endmodule
